// File: rtl/reg_file_wb_pkg.sv
// -----------------------------------------------------------------------------
// reg_file_wb_pkg
// Shared constants for the CPU general-purpose register file:
//   - default data and index widths
//   - the hard-wired zero register index
//   - conventional MIPS register indices used when addressing the file
// -----------------------------------------------------------------------------
package reg_file_wb_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  // Index 0 is the architectural zero register: never stored, always reads 0.
  localparam logic [4:0] REG_ZERO = 5'd0;

  // Conventional register indices.
  localparam logic [4:0] REG_SP = 5'd29;  // $sp
  localparam logic [4:0] REG_RA = 5'd31;  // $ra

endpackage : reg_file_wb_pkg

// File: rtl/reg_file_wb_wt_addr_decoder.sv
// -----------------------------------------------------------------------------
// wt_addr_decoder
// ADDR_W-to-2**ADDR_W one-hot decoder with enable. It turns the write-register
// index into per-register write enables. Output bit 0 is tied low, so a write
// aimed at the zero register never reaches any storage.
//
// Ports:
//   i_addr   in   ADDR_W      index to decode
//   i_en     in   1           enable; only a definite 1 produces an output bit
//   o_onehot out  2**ADDR_W   one-hot enable vector (all zero when disabled)
// -----------------------------------------------------------------------------
module wt_addr_decoder #(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]      i_addr,
  input  logic                   i_en,
  output logic [2**ADDR_W-1:0]   o_onehot
);

  // NOTE: every output bit gets a default before the conditional assignment,
  // so no path through the block leaves a bit unassigned and no latch forms.
  always_comb begin
    o_onehot = '0;
    // A case-equality compare keeps an X enable from spreading into the
    // vector in simulation; synthesis treats it as a plain compare.
    if (i_en === 1'b1) begin
      o_onehot[i_addr] = 1'b1;
    end
    o_onehot[0] = 1'b0;
  end

endmodule : wt_addr_decoder

// File: rtl/reg_file_wb.sv
// -----------------------------------------------------------------------------
// reg_file_wb
// 32 x 32-bit general-purpose register file for a single-cycle CPU.
// Two combinational operand read ports, one combinational debug read port and
// one synchronous write port. Register 0 is not stored and always reads 0.
// No write-to-read bypass: a same-cycle read of the write target returns the
// old value until the clock edge.
//
// Ports:
//   clk        in   1       system clock, rising edge
//   rst        in   1       synchronous active-high reset
//   R_addr_A   in   ADDR_W  read port A index (rs)
//   R_addr_B   in   ADDR_W  read port B index (rt)
//   Wt_addr    in   ADDR_W  write index from the write-register select
//   Wt_data    in   DATA_W  write-back data
//   L_S        in   1       write enable (RegWrite)
//   rdata_A    out  DATA_W  contents of R_addr_A
//   rdata_B    out  DATA_W  contents of R_addr_B
//   dbg_addr   in   ADDR_W  debug read index
//   dbg_data   out  DATA_W  contents of dbg_addr
//   wr_strobe  out  1       high for the cycle after a committed write
// -----------------------------------------------------------------------------
module reg_file_wb
  import reg_file_wb_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] R_addr_A,
  input  logic [ADDR_W-1:0] R_addr_B,
  input  logic [ADDR_W-1:0] Wt_addr,
  input  logic [DATA_W-1:0] Wt_data,
  input  logic              L_S,
  output logic [DATA_W-1:0] rdata_A,
  output logic [DATA_W-1:0] rdata_B,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic              wr_strobe
);

  localparam int NREG = 2**ADDR_W;

  logic [NREG-1:0]   w_we;
  logic [DATA_W-1:0] r_regs [1:NREG-1];
  logic              r_wr_strobe;

  wt_addr_decoder #(
    .ADDR_W   (ADDR_W)
  ) u_wt_addr_decoder (
    .i_addr   (Wt_addr),
    .i_en     (L_S),
    .o_onehot (w_we)
  );

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its inputs, independent of statement order.
  // NOTE: the register array is reset explicitly; the CPU relies on a known
  // all-zero file after reset, so it is built from flops rather than a RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_wr_strobe <= 1'b0;
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (w_we[i]) begin
          r_regs[i] <= Wt_data;
        end
      end
      // Bit 0 is always low, so an index-0 or disabled write leaves this at 0.
      r_wr_strobe <= |w_we;
    end
  end

  // Index 0 has no storage, so the default of 0 stands for it.
  always_comb begin
    rdata_A  = '0;
    rdata_B  = '0;
    dbg_data = '0;
    for (int i = 1; i < NREG; i++) begin
      if (R_addr_A == ADDR_W'(i)) rdata_A  = r_regs[i];
      if (R_addr_B == ADDR_W'(i)) rdata_B  = r_regs[i];
      if (dbg_addr == ADDR_W'(i)) dbg_data = r_regs[i];
    end
  end

  assign wr_strobe = r_wr_strobe;

endmodule : reg_file_wb

// File: tb/tb_reg_file_wb.sv
// -----------------------------------------------------------------------------
// tb_reg_file_wb
// Self-checking bench for reg_file_wb. A behavioural register model supplies
// expected read values, which are queued when read addresses are driven and
// popped when the outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_reg_file_wb;
  import reg_file_wb_pkg::*;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] R_addr_A, R_addr_B, Wt_addr, dbg_addr;
  logic [DW-1:0] Wt_data;
  logic          L_S;
  logic [DW-1:0] rdata_A, rdata_B, dbg_data;
  logic          wr_strobe;

  always #5 clk = ~clk;

  reg_file_wb #(
    .DATA_W    (DW),
    .ADDR_W    (AW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .R_addr_A  (R_addr_A),
    .R_addr_B  (R_addr_B),
    .Wt_addr   (Wt_addr),
    .Wt_data   (Wt_data),
    .L_S       (L_S),
    .rdata_A   (rdata_A),
    .rdata_B   (rdata_B),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .wr_strobe (wr_strobe)
  );

  typedef struct {
    string         name;
    logic [DW-1:0] exp;
  } sb_t;

  sb_t           sb_q[$];
  int            n_pass  = 0;
  int            n_total = 0;
  logic [DW-1:0] model [0:31];
  logic          exp_strobe;

  // Drive one clock of write/reset stimulus and advance the model.
  task automatic commit(input logic r, input logic en, input logic [AW-1:0] a,
                        input logic [DW-1:0] d);
    rst = r; L_S = en; Wt_addr = a; Wt_data = d;
    @(posedge clk); #1;
    if (r) begin
      for (int i = 0; i < 32; i++) model[i] = '0;
      exp_strobe = 1'b0;
    end else begin
      if (en && a != REG_ZERO) model[a] = d;
      exp_strobe = en && (a != REG_ZERO);
    end
    rst = 1'b0; L_S = 1'b0;
  endtask

  // Drive read addresses and queue the values the model says they must show.
  task automatic set_reads(input logic [AW-1:0] a, input logic [AW-1:0] b,
                           input logic [AW-1:0] d);
    R_addr_A = a; R_addr_B = b; dbg_addr = d;
    sb_q.push_back('{name: $sformatf("rdata_A[%0d]", a), exp: model[a]});
    sb_q.push_back('{name: $sformatf("rdata_B[%0d]", b), exp: model[b]});
    sb_q.push_back('{name: $sformatf("dbg_data[%0d]", d), exp: model[d]});
  endtask

  task automatic test_reset();
    sb_t it;
    commit(1'b1, 1'b0, '0, '0);
    commit(1'b1, 1'b0, '0, '0);
    set_reads(5'd5, REG_RA, REG_ZERO);
    @(negedge clk);
    it = sb_q.pop_front(); n_total++;
    if (rdata_A !== it.exp) $display("FAIL reset %s: got %h want %h", it.name, rdata_A, it.exp); else n_pass++;
    it = sb_q.pop_front(); n_total++;
    if (rdata_B !== it.exp) $display("FAIL reset %s: got %h want %h", it.name, rdata_B, it.exp); else n_pass++;
    it = sb_q.pop_front(); n_total++;
    if (dbg_data !== it.exp) $display("FAIL reset %s: got %h want %h", it.name, dbg_data, it.exp); else n_pass++;
    n_total++;
    if (wr_strobe !== exp_strobe) $display("FAIL reset wr_strobe: got %b want %b", wr_strobe, exp_strobe); else n_pass++;

    // Preload reg 5, then reset with a competing write to reg 5.
    commit(1'b0, 1'b1, 5'd5, 32'h0000_1234);
    commit(1'b1, 1'b1, 5'd5, 32'h0000_FFFF);
    set_reads(5'd5, 5'd5, 5'd5);
    @(negedge clk);
    it = sb_q.pop_front(); n_total++;
    if (rdata_A !== it.exp) $display("FAIL rst_drop %s: got %h want %h", it.name, rdata_A, it.exp); else n_pass++;
    it = sb_q.pop_front(); n_total++;
    if (rdata_B !== it.exp) $display("FAIL rst_drop %s: got %h want %h", it.name, rdata_B, it.exp); else n_pass++;
    it = sb_q.pop_front(); n_total++;
    if (dbg_data !== it.exp) $display("FAIL rst_drop %s: got %h want %h", it.name, dbg_data, it.exp); else n_pass++;
    n_total++;
    if (wr_strobe !== 1'b0) $display("FAIL rst_drop wr_strobe: got %b want 0", wr_strobe); else n_pass++;
  endtask

  task automatic test_basic();
    sb_t it;
    commit(1'b0, 1'b1, 5'd8, 32'hDEAD_BEEF);
    n_total++;
    if (wr_strobe !== exp_strobe) $display("FAIL basic wr_strobe(8): got %b want %b", wr_strobe, exp_strobe); else n_pass++;
    commit(1'b0, 1'b1, REG_RA, 32'h0000_0001);
    set_reads(5'd8, REG_RA, REG_RA);
    @(negedge clk);
    it = sb_q.pop_front(); n_total++;
    if (rdata_A !== it.exp) $display("FAIL basic %s: got %h want %h", it.name, rdata_A, it.exp); else n_pass++;
    it = sb_q.pop_front(); n_total++;
    if (rdata_B !== it.exp) $display("FAIL basic %s: got %h want %h", it.name, rdata_B, it.exp); else n_pass++;
    it = sb_q.pop_front(); n_total++;
    if (dbg_data !== it.exp) $display("FAIL basic %s: got %h want %h", it.name, dbg_data, it.exp); else n_pass++;
    n_total++;
    if (wr_strobe !== exp_strobe) $display("FAIL basic wr_strobe(31): got %b want %b", wr_strobe, exp_strobe); else n_pass++;
  endtask

  task automatic test_zero_reg();
    sb_t it;
    commit(1'b0, 1'b1, REG_ZERO, 32'hFFFF_FFFF);
    set_reads(REG_ZERO, 5'd8, REG_RA);
    @(negedge clk);
    it = sb_q.pop_front(); n_total++;
    if (rdata_A !== it.exp) $display("FAIL zero %s: got %h want %h", it.name, rdata_A, it.exp); else n_pass++;
    it = sb_q.pop_front(); n_total++;
    if (rdata_B !== it.exp) $display("FAIL zero %s: got %h want %h", it.name, rdata_B, it.exp); else n_pass++;
    it = sb_q.pop_front(); n_total++;
    if (dbg_data !== it.exp) $display("FAIL zero %s: got %h want %h", it.name, dbg_data, it.exp); else n_pass++;
    n_total++;
    if (wr_strobe !== exp_strobe) $display("FAIL zero wr_strobe: got %b want %b", wr_strobe, exp_strobe); else n_pass++;
  endtask

  task automatic test_same_cycle();
    sb_t it;
    commit(1'b0, 1'b1, 5'd3, 32'h0000_000A);
    // Present the write to reg 3 and read reg 3 before the edge.
    L_S = 1'b1; Wt_addr = 5'd3; Wt_data = 32'h0000_000B;
    set_reads(5'd3, 5'd3, 5'd3);
    @(negedge clk);
    it = sb_q.pop_front(); n_total++;
    if (rdata_A !== it.exp) $display("FAIL same_pre %s: got %h want %h", it.name, rdata_A, it.exp); else n_pass++;
    it = sb_q.pop_front(); n_total++;
    if (rdata_B !== it.exp) $display("FAIL same_pre %s: got %h want %h", it.name, rdata_B, it.exp); else n_pass++;
    it = sb_q.pop_front(); n_total++;
    if (dbg_data !== it.exp) $display("FAIL same_pre %s: got %h want %h", it.name, dbg_data, it.exp); else n_pass++;
    @(posedge clk); #1;
    model[3] = 32'h0000_000B;
    exp_strobe = 1'b1;
    L_S = 1'b0;
    set_reads(5'd3, 5'd3, 5'd3);
    @(negedge clk);
    it = sb_q.pop_front(); n_total++;
    if (rdata_A !== it.exp) $display("FAIL same_post %s: got %h want %h", it.name, rdata_A, it.exp); else n_pass++;
    it = sb_q.pop_front(); n_total++;
    if (rdata_B !== it.exp) $display("FAIL same_post %s: got %h want %h", it.name, rdata_B, it.exp); else n_pass++;
    it = sb_q.pop_front(); n_total++;
    if (dbg_data !== it.exp) $display("FAIL same_post %s: got %h want %h", it.name, dbg_data, it.exp); else n_pass++;
    n_total++;
    if (wr_strobe !== exp_strobe) $display("FAIL same_post wr_strobe: got %b want %b", wr_strobe, exp_strobe); else n_pass++;
  endtask

  task automatic test_enable_gating();
    sb_t it;
    commit(1'b0, 1'b1, 5'd7, 32'h0000_0077);
    commit(1'b0, 1'b0, 5'd7, 32'h0000_0055);
    set_reads(5'd7, 5'd7, 5'd7);
    @(negedge clk);
    it = sb_q.pop_front(); n_total++;
    if (rdata_A !== it.exp) $display("FAIL gate %s: got %h want %h", it.name, rdata_A, it.exp); else n_pass++;
    it = sb_q.pop_front(); n_total++;
    if (rdata_B !== it.exp) $display("FAIL gate %s: got %h want %h", it.name, rdata_B, it.exp); else n_pass++;
    it = sb_q.pop_front(); n_total++;
    if (dbg_data !== it.exp) $display("FAIL gate %s: got %h want %h", it.name, dbg_data, it.exp); else n_pass++;
    n_total++;
    if (wr_strobe !== 1'b0) $display("FAIL gate wr_strobe: got %b want 0", wr_strobe); else n_pass++;

    // Distinct value in every nonzero register, then read all back.
    for (int i = 1; i < 32; i++) commit(1'b0, 1'b1, AW'(i), 32'h100 + DW'(i));
    for (int i = 1; i < 32; i++) begin
      set_reads(AW'(i), AW'(32 - i), AW'(i));
      @(negedge clk);
      it = sb_q.pop_front(); n_total++;
      if (rdata_A !== it.exp) $display("FAIL sweep %s: got %h want %h", it.name, rdata_A, it.exp); else n_pass++;
      it = sb_q.pop_front(); n_total++;
      if (rdata_B !== it.exp) $display("FAIL sweep %s: got %h want %h", it.name, rdata_B, it.exp); else n_pass++;
      it = sb_q.pop_front(); n_total++;
      if (dbg_data !== it.exp) $display("FAIL sweep %s: got %h want %h", it.name, dbg_data, it.exp); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_dual_port();
    sb_t it;
    commit(1'b0, 1'b1, 5'd12, 32'h0000_CAFE);
    set_reads(5'd12, 5'd12, REG_SP);
    @(negedge clk);
    it = sb_q.pop_front(); n_total++;
    if (rdata_A !== it.exp) $display("FAIL dual %s: got %h want %h", it.name, rdata_A, it.exp); else n_pass++;
    it = sb_q.pop_front(); n_total++;
    if (rdata_B !== it.exp) $display("FAIL dual %s: got %h want %h", it.name, rdata_B, it.exp); else n_pass++;
    it = sb_q.pop_front(); n_total++;
    if (dbg_data !== it.exp) $display("FAIL dual %s: got %h want %h", it.name, dbg_data, it.exp); else n_pass++;
  endtask

  task automatic test_x_enable();
    sb_t it;
    // An unknown enable must not touch storage or raise the strobe.
    rst = 1'b0; L_S = 1'bx; Wt_addr = REG_SP; Wt_data = 32'h5A5A_5A5A;
    @(posedge clk); #1;
    L_S = 1'b0;
    set_reads(REG_SP, 5'd12, REG_SP);
    @(negedge clk);
    it = sb_q.pop_front(); n_total++;
    if (rdata_A !== it.exp) $display("FAIL xen %s: got %h want %h", it.name, rdata_A, it.exp); else n_pass++;
    it = sb_q.pop_front(); n_total++;
    if (rdata_B !== it.exp) $display("FAIL xen %s: got %h want %h", it.name, rdata_B, it.exp); else n_pass++;
    it = sb_q.pop_front(); n_total++;
    if (dbg_data !== it.exp) $display("FAIL xen %s: got %h want %h", it.name, dbg_data, it.exp); else n_pass++;
    n_total++;
    if (wr_strobe !== 1'b0) $display("FAIL xen wr_strobe: got %b want 0", wr_strobe); else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; L_S = 1'b0; Wt_addr = '0; Wt_data = '0;
    R_addr_A = '0; R_addr_B = '0; dbg_addr = '0;
    exp_strobe = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;

    test_reset();
    test_basic();
    test_zero_reg();
    test_same_cycle();
    test_enable_gating();
    test_dual_port();
    test_x_enable();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule : tb_reg_file_wb

// File: doc/reg_file_wb.md
Name: reg_file_wb

Overview:
- 32 x 32-bit general-purpose register file for the single-cycle CPU.
- Consumer end of the 5-bit write-register select path: the selected destination index (rt/rd choice from the 5-bit 2:1 select) arrives on Wt_addr and is decoded 1-of-32 into per-register write enables.
- Two combinational read ports feed the ALU operand path; a third debug read port feeds the board display.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; register count = 2**ADDR_W

Ports:
- clk  input  1  system clock; all state changes on posedge
- rst  input  1  synchronous, active-high reset; sampled on posedge clk
- R_addr_A  input  ADDR_W  read port A index (rs)
- R_addr_B  input  ADDR_W  read port B index (rt)
- Wt_addr  input  ADDR_W  write index from the write-register select
- Wt_data  input  DATA_W  write-back data
- L_S  input  1  write enable (RegWrite)
- rdata_A  output  DATA_W  contents of R_addr_A
- rdata_B  output  DATA_W  contents of R_addr_B
- dbg_addr  input  ADDR_W  debug read index
- dbg_data  output  DATA_W  contents of dbg_addr
- wr_strobe  output  1  registered pulse: 1 for the cycle after a committed write to a nonzero index

Behaviour:
- Storage: registers 1..31 are flops. Register 0 is not stored; every read of index 0 returns 0.
- Reset: on posedge clk with rst=1, registers 1..31 clear to 0 and wr_strobe clears to 0. rst has priority over L_S in the same cycle. rdata_A, rdata_B and dbg_data read 0 from the first edge after reset onward, for any address.
- Write decode: Wt_addr is decoded to a 32-bit one-hot enable vector, gated by L_S. Bit 0 of the vector is forced to 0.
- Write: on posedge clk with rst=0, L_S=1 and Wt_addr!=0, reg[Wt_addr] <= Wt_data. Only that one register changes.
- Ignored writes: L_S=1 with Wt_addr=0 is silently discarded. L_S=0 writes nothing.
- Read timing:
  - rdata_A = reg[R_addr_A] and rdata_B = reg[R_addr_B], purely combinational with zero-cycle latency.
  - No write-to-read bypass. A read of the index being written in the same cycle returns the old value until the edge and the new value afterwards, as single-cycle timing requires.
  - dbg_data follows the same combinational rule.
- Simultaneous events: both read ports may address the same register, or the register being written; each returns an independent, correct value.
- wr_strobe: registered. It is 1 in the cycle following an edge that committed a write, else 0. It is 0 after any reset edge.
- Reset mid-operation: a write presented in the same cycle as rst=1 is dropped. No partial state remains.
- X handling: an X on L_S must not corrupt registers in simulation. Guard the enable as a strict 1'b1 compare.

Decomposition:
- Shared package/header holds:
  - DATA_W and ADDR_W defaults
  - REG_ZERO = 5'd0
  - named constants for conventional indices ($ra=31, $sp=29) used by the bench
- One sub-module, wt_addr_decoder: ADDR_W-to-2**ADDR_W one-hot decoder with an enable input. It is the demultiplexing counterpart of the 5-bit write-register select, and register 0's output is tied low inside it.

Test Plan:
- Reset clear: preload reg[5]=0x1234, assert rst one cycle with L_S=1, Wt_addr=5, Wt_data=0xFFFF -> after the edge, reads of 5 return 0x00000000 and wr_strobe=0.
- Basic write/read: write 0xDEADBEEF to index 8, then 0x00000001 to index 31 -> R_addr_A=8 gives 0xDEADBEEF, R_addr_B=31 gives 0x00000001, dbg_addr=31 gives 0x00000001, wr_strobe=1 in each following cycle.
- Zero register: L_S=1, Wt_addr=0, Wt_data=0xFFFFFFFF -> reads of index 0 stay 0, no other register changes, wr_strobe=0 next cycle.
- Same-cycle read of write target: reg[3]=0xA, write 0xB to index 3 with R_addr_A=3 -> rdata_A=0xA before the edge and 0xB after.
- Enable gating: L_S=0 with Wt_addr=7, Wt_data=0x55 -> reg[7] unchanged. Then sweep all 31 nonzero indices with a distinct value each (0x100+i) and read all of them back on both ports, confirming one-hot decode with no aliasing.
- Dual-port same address: R_addr_A=R_addr_B=12 with reg[12]=0xCAFE -> both outputs return 0xCAFE simultaneously.
